// File: rtl/alu_pkg.sv
// Shared types for the RV32I ALU: operation encodings and the default datapath width.
// Optional build macro ALU_OVERFLOW_EN adds a signed-overflow flag to the ALU.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_XOR  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001,
        ALU_BEQ  = 4'b1010,
        ALU_BNE  = 4'b1011,
        ALU_BLT  = 4'b1100,
        ALU_BGE  = 4'b1101,
        ALU_BLTU = 4'b1110,
        ALU_BGEU = 4'b1111
    } alu_op_e;

endpackage

// File: rtl/alu_comb.sv
// Purely combinational RV32I operation and branch-condition evaluation.
// Optional build macro ALU_OVERFLOW_EN adds the signed-overflow output for ADD/SUB.
module alu_comb
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  alu_op_e           op,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [XLEN-1:0]   result,
    output logic              zero
`ifdef ALU_OVERFLOW_EN
    ,
    output logic              overflow
`endif
);

    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic [SHW-1:0]  shamt;
    logic            lt_signed;
    logic            lt_unsigned;
    logic            equal;
    logic            is_branch;
    logic            cond;

    assign sum         = a + b;
    assign diff        = a - b;
    assign shamt       = b[SHW-1:0];
    assign lt_signed   = $signed(a) < $signed(b);
    assign lt_unsigned = a < b;
    assign equal       = (a == b);

    always_comb begin
        result    = '0;
        cond      = 1'b0;
        is_branch = 1'b0;
        case (op)
            ALU_ADD:  result = sum;
            ALU_SUB:  result = diff;
            ALU_XOR:  result = a ^ b;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt_signed};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, lt_unsigned};
            ALU_BEQ:  begin is_branch = 1'b1; cond = equal;        end
            ALU_BNE:  begin is_branch = 1'b1; cond = !equal;       end
            ALU_BLT:  begin is_branch = 1'b1; cond = lt_signed;    end
            ALU_BGE:  begin is_branch = 1'b1; cond = !lt_signed;   end
            ALU_BLTU: begin is_branch = 1'b1; cond = lt_unsigned;  end
            ALU_BGEU: begin is_branch = 1'b1; cond = !lt_unsigned; end
            default:  result = '0;
        endcase
        if (is_branch) begin
            result = {{(XLEN-1){1'b0}}, cond};
        end
    end

    // For branches the flag means "taken"; otherwise it flags a zero result.
    assign zero = is_branch ? cond : (result == '0);

`ifdef ALU_OVERFLOW_EN
    always_comb begin
        overflow = 1'b0;
        if (op == ALU_ADD) begin
            overflow = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
        end else if (op == ALU_SUB) begin
            overflow = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
        end
    end
`endif

endmodule

// File: rtl/riscv_alu.sv
// RV32I ALU with a single registered output stage (latency 1, no backpressure).
// Optional build macro ALU_OVERFLOW_EN adds the registered `overflow` output.
module riscv_alu
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [3:0]        alu_control,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    output logic [XLEN-1:0]   alu_out,
    output logic              zero,
    output logic              out_valid
`ifdef ALU_OVERFLOW_EN
    ,
    output logic              overflow
`endif
);

    logic [XLEN-1:0] comb_result;
    logic            comb_zero;
`ifdef ALU_OVERFLOW_EN
    logic            comb_overflow;
`endif

    alu_comb #(.XLEN(XLEN)) u_alu_comb (
        .op       (alu_op_e'(alu_control)),
        .a        (rs1_data),
        .b        (rs2_data),
        .result   (comb_result),
        .zero     (comb_zero)
`ifdef ALU_OVERFLOW_EN
        ,
        .overflow (comb_overflow)
`endif
    );

    // Results only update on accepted ops, so idle cycles hold the last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_out   <= '0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
`ifdef ALU_OVERFLOW_EN
            overflow  <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                alu_out  <= comb_result;
                zero     <= comb_zero;
`ifdef ALU_OVERFLOW_EN
                overflow <= comb_overflow;
`endif
            end
        end
    end

endmodule

// File: tb/tb_riscv_alu.sv
// Self-checking bench for riscv_alu: reset, table-driven streaming vectors, hold and reset-discard sequences.
// Builds with or without ALU_OVERFLOW_EN; the overflow flag is checked only when the macro is defined.
module tb_riscv_alu;
    import alu_pkg::*;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic [3:0]      alu_control;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] alu_out;
    logic            zero;
    logic            out_valid;
`ifdef ALU_OVERFLOW_EN
    logic            overflow;
`endif

    int checks;
    int failures;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
        logic        exp_zero;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[$];

    riscv_alu #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .alu_control (alu_control),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .alu_out     (alu_out),
        .zero        (zero),
        .out_valid   (out_valid)
`ifdef ALU_OVERFLOW_EN
        ,
        .overflow    (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge so they are stable at the capturing rising edge.
    task automatic applyStimulus(input logic valid, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
        in_valid    = valid;
        alu_control = op;
        rs1_data    = a;
        rs2_data    = b;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] exp_out,
                               input logic exp_zero, input logic exp_valid,
                               input logic exp_ovf);
        checks++;
        if (alu_out !== exp_out) begin
            failures++;
            $display("[TB] FAIL %s alu_out: got %08h expected %08h", name, alu_out, exp_out);
        end
        checks++;
        if (zero !== exp_zero) begin
            failures++;
            $display("[TB] FAIL %s zero: got %0b expected %0b", name, zero, exp_zero);
        end
        checks++;
        if (out_valid !== exp_valid) begin
            failures++;
            $display("[TB] FAIL %s out_valid: got %0b expected %0b", name, out_valid, exp_valid);
        end
`ifdef ALU_OVERFLOW_EN
        checks++;
        if (overflow !== exp_ovf) begin
            failures++;
            $display("[TB] FAIL %s overflow: got %0b expected %0b", name, overflow, exp_ovf);
        end
`else
        if (exp_ovf === 1'bx) $display("[TB] unexpected unknown overflow expectation in %s", name);
`endif
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] r, input logic z, input logic v);
        vec_t t;
        t.op = op; t.a = a; t.b = b; t.exp_out = r; t.exp_zero = z; t.exp_ovf = v;
        return t;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        applyStimulus(1'b1, ALU_ADD, 32'd10, 32'd20);

        // Arithmetic / logic
        vecs.push_back(mk(ALU_ADD,  32'd10,        32'd20,        32'd30,        1'b0, 1'b0));
        vecs.push_back(mk(ALU_SUB,  32'd30,        32'd10,        32'd20,        1'b0, 1'b0));
        vecs.push_back(mk(ALU_XOR,  32'hFF00FF00,  32'h00FF00FF,  32'hFFFFFFFF,  1'b0, 1'b0));
        vecs.push_back(mk(ALU_OR,   32'hA5A5A5A5,  32'h5A5A5A5A,  32'hFFFFFFFF,  1'b0, 1'b0));
        vecs.push_back(mk(ALU_AND,  32'hFFFF0000,  32'h00FFFF00,  32'h00FF0000,  1'b0, 1'b0));
        // Shifts / compares
        vecs.push_back(mk(ALU_SLL,  32'd1,         32'd4,         32'd16,        1'b0, 1'b0));
        vecs.push_back(mk(ALU_SRL,  32'd16,        32'd2,         32'd4,         1'b0, 1'b0));
        vecs.push_back(mk(ALU_SRA,  32'hFFFFFFF8,  32'd1,         32'hFFFFFFFC,  1'b0, 1'b0));
        vecs.push_back(mk(ALU_SRL,  32'h80000000,  32'd31,        32'd1,         1'b0, 1'b0));
        vecs.push_back(mk(ALU_SLT,  32'hFFFFFFFB,  32'd3,         32'd1,         1'b0, 1'b0));
        vecs.push_back(mk(ALU_SLTU, 32'd5,         32'd10,        32'd1,         1'b0, 1'b0));
        vecs.push_back(mk(ALU_SLTU, 32'hFFFFFFFB,  32'd3,         32'd0,         1'b1, 1'b0));
        // Branches
        vecs.push_back(mk(ALU_BEQ,  32'd15,        32'd15,        32'd1,         1'b1, 1'b0));
        vecs.push_back(mk(ALU_BNE,  32'd20,        32'd25,        32'd1,         1'b1, 1'b0));
        vecs.push_back(mk(ALU_BLT,  32'hFFFFFFFB,  32'd1,         32'd1,         1'b1, 1'b0));
        vecs.push_back(mk(ALU_BGE,  32'd10,        32'd5,         32'd1,         1'b1, 1'b0));
        vecs.push_back(mk(ALU_BLTU, 32'd5,         32'd10,        32'd1,         1'b1, 1'b0));
        vecs.push_back(mk(ALU_BGEU, 32'd100,       32'd50,        32'd1,         1'b1, 1'b0));
        vecs.push_back(mk(ALU_BLTU, 32'hFFFFFFFB,  32'd1,         32'd0,         1'b0, 1'b0));
        vecs.push_back(mk(ALU_BEQ,  32'd3,         32'd4,         32'd0,         1'b0, 1'b0));
        vecs.push_back(mk(ALU_BNE,  32'd7,         32'd7,         32'd0,         1'b0, 1'b0));
        vecs.push_back(mk(ALU_BGE,  32'hFFFFFFFF,  32'd0,         32'd0,         1'b0, 1'b0));
        vecs.push_back(mk(ALU_BGEU, 32'd0,         32'd1,         32'd0,         1'b0, 1'b0));
        // Boundaries
        vecs.push_back(mk(ALU_ADD,  32'hFFFFFFFF,  32'd1,         32'd0,         1'b1, 1'b0));
        vecs.push_back(mk(ALU_SUB,  32'd0,         32'd1,         32'hFFFFFFFF,  1'b0, 1'b0));
        vecs.push_back(mk(ALU_SLT,  32'h80000000,  32'd0,         32'd1,         1'b0, 1'b0));
        vecs.push_back(mk(ALU_SLTU, 32'h80000000,  32'd0,         32'd0,         1'b1, 1'b0));
        vecs.push_back(mk(ALU_SLL,  32'd1,         32'd32,        32'd1,         1'b0, 1'b0));
        vecs.push_back(mk(ALU_ADD,  32'h7FFFFFFF,  32'd1,         32'h80000000,  1'b0, 1'b1));
        vecs.push_back(mk(ALU_SUB,  32'h80000000,  32'd1,         32'h7FFFFFFF,  1'b0, 1'b1));
        vecs.push_back(mk(ALU_XOR,  32'h12345678,  32'h12345678,  32'd0,         1'b1, 1'b0));

        // Reset held two cycles with a valid op presented: nothing may be captured.
        @(posedge clk); #1;
        checkOutput("reset_cycle1", 32'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        checkOutput("reset_cycle2", 32'd0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, ALU_ADD, 32'd10, 32'd20);
        @(negedge clk);
        checkOutput("first_after_reset", 32'd30, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, ALU_SUB, 32'd0, 32'd0);
        @(negedge clk);
        checkOutput("idle_hold", 32'd30, 1'b0, 1'b0, 1'b0);

        // Back-to-back stream of the whole table: each result exactly one cycle later.
        for (int i = 0; i < vecs.size(); i++) begin
            if (i > 0) begin
                checkOutput($sformatf("vec%0d_op%0h", i - 1, vecs[i-1].op),
                            vecs[i-1].exp_out, vecs[i-1].exp_zero, 1'b1, vecs[i-1].exp_ovf);
            end
            applyStimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            @(negedge clk);
        end
        checkOutput($sformatf("vec%0d_op%0h", vecs.size() - 1, vecs[vecs.size()-1].op),
                    vecs[vecs.size()-1].exp_out, vecs[vecs.size()-1].exp_zero, 1'b1,
                    vecs[vecs.size()-1].exp_ovf);

        // Drop in_valid with different operands: outputs must hold the last result.
        applyStimulus(1'b0, ALU_ADD, 32'd1, 32'd2);
        @(negedge clk);
        checkOutput("stream_end_hold1", 32'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("stream_end_hold2", 32'd0, 1'b1, 1'b0, 1'b0);

        // Overflowing op, then hold, then reset discards an in-flight op.
        applyStimulus(1'b1, ALU_ADD, 32'h7FFFFFFF, 32'd1);
        @(negedge clk);
        checkOutput("ovf_add", 32'h80000000, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, ALU_OR, 32'hF0F0F0F0, 32'h0F0F0F0F);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("reset_discard", 32'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(1'b1, ALU_SRA, 32'h80000000, 32'd4);
        @(negedge clk);
        checkOutput("sra_after_reset", 32'hF8000000, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, ALU_ADD, 32'd0, 32'd0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
